// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 control unit: opcodes, FS codes, FSM
// states, immediate selects and control-word field positions.
// Optional macro: LEGV8_CU_BCOND_EN (ADDS/SUBS, flag register, B.cond).
package legv8_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_D,
        IMM_CB,
        IMM_B
    } imm_sel_t;

    typedef enum logic [3:0] {
        K_ILLEGAL,
        K_RTYPE,
        K_ITYPE,
        K_LDUR,
        K_STUR,
        K_CBZ,
        K_CBNZ,
        K_B,
        K_BCOND
    } kind_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
`ifdef LEGV8_CU_BCOND_EN
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
`endif

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    // ControlWord = {SA[4:0],SB[4:0],DA[4:0],RegWrite,MemWrite,FS[4:0],SD}
    localparam int unsigned CW_WIDTH  = 23;
    localparam int unsigned CW_SA_LSB = 18;
    localparam int unsigned CW_SB_LSB = 13;
    localparam int unsigned CW_DA_LSB = 8;
    localparam int unsigned CW_RW     = 7;
    localparam int unsigned CW_MW     = 6;
    localparam int unsigned CW_FS_LSB = 1;
    localparam int unsigned CW_SD     = 0;

    // Widest opcode field wins: 11-bit, then 10-bit, then 8-bit, then 6-bit.
    function automatic kind_t classify(input logic [31:0] ir);
        kind_t k;
        k = K_ILLEGAL;
        case (ir[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR: k = K_RTYPE;
`ifdef LEGV8_CU_BCOND_EN
            OP_ADDS, OP_SUBS:               k = K_RTYPE;
`endif
            OP_LDUR:                        k = K_LDUR;
            OP_STUR:                        k = K_STUR;
            default: begin
                if (ir[31:22] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI})
                    k = K_ITYPE;
                else if (ir[31:24] == OP_CBZ)
                    k = K_CBZ;
                else if (ir[31:24] == OP_CBNZ)
                    k = K_CBNZ;
`ifdef LEGV8_CU_BCOND_EN
                else if (ir[31:24] == OP_BCOND)
                    k = K_BCOND;
`endif
                else if (ir[31:26] == OP_B)
                    k = K_B;
            end
        endcase
        return k;
    endfunction

    function automatic logic [4:0] r_fs(input logic [10:0] op);
        logic [4:0] fs;
        case (op)
            OP_SUB:  fs = FS_SUB;
`ifdef LEGV8_CU_BCOND_EN
            OP_SUBS: fs = FS_SUB;
`endif
            OP_AND:  fs = FS_AND;
            OP_ORR:  fs = FS_ORR;
            default: fs = FS_ADD;
        endcase
        return fs;
    endfunction

    function automatic logic [4:0] i_fs(input logic [9:0] op);
        logic [4:0] fs;
        case (op)
            OP_SUBI: fs = FS_SUB;
            OP_ANDI: fs = FS_AND;
            OP_ORRI: fs = FS_ORR;
            default: fs = FS_ADD;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate generator: datapath constant (I/D forms) and the byte branch
// offset (CB/B forms, already shifted left by 2) from the IR body.
module legv8_imm_gen
    import legv8_pkg::*;
(
    input  logic [25:0] ir_body,
    input  imm_sel_t    imm_sel,
    output logic [63:0] const_val,
    output logic [63:0] br_offset
);

    // Select and extend the immediate field for the current instruction form
    always_comb begin
        const_val = '0;
        br_offset = '0;
        case (imm_sel)
            IMM_I:   const_val = {52'b0, ir_body[21:10]};
            IMM_D:   const_val = {{55{ir_body[20]}}, ir_body[20:12]};
            IMM_CB:  br_offset = {{43{ir_body[23]}}, ir_body[23:5], 2'b00};
            IMM_B:   br_offset = {{36{ir_body[25]}}, ir_body[25:0], 2'b00};
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multicycle LEGv8 sequencer: FETCH (req/ack) -> EXEC (one cycle) -> FETCH,
// HALT on an unrecognised opcode until reset.
// Optional macro: LEGV8_CU_BCOND_EN adds ADDS/SUBS, the NZCV flag register
// and B.cond.
module legv8_control_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic [63:0]         imem_addr,
    input  logic [31:0]         imem_data,
    input  logic [3:0]          status,
    output logic [CW_WIDTH-1:0] ControlWord,
    output logic [63:0]         Const,
    output logic                Bsel,
    output logic                halted,
    output logic                illegal
);

    state_t                state, state_next;
    logic [63:0]           pc;
    logic [31:0]           ir;
    kind_t                 kind;
    imm_sel_t              imm_sel;
    logic [63:0]           imm_const, br_offset;
    logic [CW_WIDTH-1:0]   cw;
    logic                  bsel_d, taken, exec;

    assign kind = classify(ir);
    assign exec = (state == EXEC);

    legv8_imm_gen u_imm_gen (
        .ir_body   (ir[25:0]),
        .imm_sel   (imm_sel),
        .const_val (imm_const),
        .br_offset (br_offset)
    );

`ifdef LEGV8_CU_BCOND_EN
    logic [3:0] flags;   // {V,C,N,Z}, same order as status

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic r;
        case (cond[3:1])
            3'd0:    r = f[0];
            3'd1:    r = f[2];
            3'd2:    r = f[1];
            3'd3:    r = f[3];
            3'd4:    r = f[2] & ~f[0];
            3'd5:    r = (f[1] == f[3]);
            3'd6:    r = ~f[0] & (f[1] == f[3]);
            default: r = 1'b1;
        endcase
        // Odd codes invert their even partner; 1111 stays "always".
        return (cond[0] && cond[3:1] != 3'b111) ? ~r : r;
    endfunction

    // Latch ALU flags at the end of an ADDS/SUBS execute cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            flags <= '0;
        else if (exec && (ir[31:21] == OP_ADDS || ir[31:21] == OP_SUBS))
            flags <= status;
    end
`else
    logic unused_status;
    assign unused_status = ^status[3:1];
`endif

    // Decode the IR into control word, immediate select and branch decision
    always_comb begin
        cw      = '0;
        imm_sel = IMM_NONE;
        bsel_d  = 1'b0;
        taken   = 1'b0;
        case (kind)
            K_RTYPE: begin
                cw[CW_SA_LSB +: 5] = ir[9:5];
                cw[CW_SB_LSB +: 5] = ir[20:16];
                cw[CW_DA_LSB +: 5] = ir[4:0];
                cw[CW_RW]          = 1'b1;
                cw[CW_FS_LSB +: 5] = r_fs(ir[31:21]);
            end
            K_ITYPE: begin
                cw[CW_SA_LSB +: 5] = ir[9:5];
                cw[CW_DA_LSB +: 5] = ir[4:0];
                cw[CW_RW]          = 1'b1;
                cw[CW_FS_LSB +: 5] = i_fs(ir[31:22]);
                imm_sel            = IMM_I;
                bsel_d             = 1'b1;
            end
            K_LDUR: begin
                cw[CW_SA_LSB +: 5] = ir[9:5];
                cw[CW_DA_LSB +: 5] = ir[4:0];
                cw[CW_RW]          = 1'b1;
                cw[CW_FS_LSB +: 5] = FS_ADD;
                cw[CW_SD]          = 1'b1;
                imm_sel            = IMM_D;
                bsel_d             = 1'b1;
            end
            K_STUR: begin
                cw[CW_SA_LSB +: 5] = ir[9:5];
                cw[CW_SB_LSB +: 5] = ir[4:0];
                cw[CW_MW]          = 1'b1;
                cw[CW_FS_LSB +: 5] = FS_ADD;
                imm_sel            = IMM_D;
                bsel_d             = 1'b1;
            end
            K_CBZ, K_CBNZ: begin
                cw[CW_SA_LSB +: 5] = ir[4:0];
                cw[CW_FS_LSB +: 5] = FS_ORR;
                imm_sel            = IMM_CB;
                bsel_d             = 1'b1;
                taken              = (kind == K_CBZ) ? status[0] : ~status[0];
            end
            K_B: begin
                imm_sel = IMM_B;
                taken   = 1'b1;
            end
`ifdef LEGV8_CU_BCOND_EN
            K_BCOND: begin
                imm_sel = IMM_CB;
                taken   = cond_holds(ir[3:0], flags);
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic for the FETCH/EXEC/HALT sequencer
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ack) state_next = EXEC;
            EXEC:    state_next = (kind == K_ILLEGAL) ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    // IR capture on fetch, PC update and sticky illegal flag on execute
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: if (imem_ack) ir <= imem_data;
                EXEC: begin
                    if (kind == K_ILLEGAL)
                        illegal <= 1'b1;
                    else if (taken)
                        pc <= pc + br_offset;
                    else
                        pc <= pc + 64'(PC_STEP);
                end
                default: ;
            endcase
        end
    end

    // Datapath controls are live only in EXEC so strobes vanish with reset
    assign ControlWord = exec ? cw : '0;
    assign Const       = exec ? imm_const : '0;
    assign Bsel        = exec & bsel_d;
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Self-checking bench for legv8_control_unit (default build, macro
// LEGV8_CU_BCOND_EN undefined): vector table, randomized instructions
// against a mnemonic-level reference model, and hand-written corner cases.
module tb_legv8_control_unit;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [3:0]  status = '0;
    logic [22:0] ControlWord;
    logic [63:0] Const;
    logic        Bsel, halted, illegal;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mpc = '0;

    legv8_control_unit #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .status      (status),
        .ControlWord (ControlWord),
        .Const       (Const),
        .Bsel        (Bsel),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  st;
        logic [22:0] cw;
        logic [63:0] k;
        logic        b;
        logic [63:0] delta;
    } vec_t;

    vec_t        vecs [16];
    logic [10:0] r_ops [4];
    logic [9:0]  i_ops [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] cwp(input int unsigned sa, input int unsigned sb,
                                        input int unsigned da, input bit rw, input bit mw,
                                        input int unsigned fs, input bit sd);
        return {5'(sa), 5'(sb), 5'(da), rw, mw, 5'(fs), sd};
    endfunction

    function automatic logic [31:0] enc_r(input logic [10:0] op, input int rm, input int rn, input int rd);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input int imm, input int rn, input int rd);
        return {op, 12'(imm), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input int imm, input int rn, input int rt);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input int imm, input int rt);
        return {op, 19'(imm), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_b(input int imm);
        return {OPC_B, 26'(imm)};
    endfunction

    // Reference: name the instruction, then apply its architectural meaning.
    function automatic void ref_model(input logic [31:0] ins, input logic [3:0] st, input logic [63:0] pc,
                                      output logic [22:0] cw, output logic [63:0] k, output logic b,
                                      output logic [63:0] npc);
        string   m;
        int      rd, rn, rm, fs;
        longint  off;
        rd = int'(ins[4:0]); rn = int'(ins[9:5]); rm = int'(ins[20:16]);
        m = "ILL";
        if      (ins[31:21] == OPC_ADD)  m = "ADD";
        else if (ins[31:21] == OPC_SUB)  m = "SUB";
        else if (ins[31:21] == OPC_AND)  m = "AND";
        else if (ins[31:21] == OPC_ORR)  m = "ORR";
        else if (ins[31:21] == OPC_LDUR) m = "LDUR";
        else if (ins[31:21] == OPC_STUR) m = "STUR";
        else if (ins[31:22] == OPC_ADDI) m = "ADDI";
        else if (ins[31:22] == OPC_SUBI) m = "SUBI";
        else if (ins[31:22] == OPC_ANDI) m = "ANDI";
        else if (ins[31:22] == OPC_ORRI) m = "ORRI";
        else if (ins[31:24] == OPC_CBZ)  m = "CBZ";
        else if (ins[31:24] == OPC_CBNZ) m = "CBNZ";
        else if (ins[31:26] == OPC_B)    m = "B";
        fs = (m == "SUB" || m == "SUBI") ? 9 : (m == "AND" || m == "ANDI") ? 0 :
             (m == "ORR" || m == "ORRI") ? 4 : 8;
        cw = '0; k = '0; b = 1'b0; npc = pc + 64'd4;
        case (m)
            "ADD", "SUB", "AND", "ORR":     cw = cwp(rn, rm, rd, 1, 0, fs, 0);
            "ADDI", "SUBI", "ANDI", "ORRI": begin
                cw = cwp(rn, 0, rd, 1, 0, fs, 0); k = 64'(ins[21:10]); b = 1'b1;
            end
            "LDUR", "STUR": begin
                off = $signed(ins[20:12]);
                k   = 64'(off);
                b   = 1'b1;
                cw  = (m == "LDUR") ? cwp(rn, 0, rd, 1, 0, 8, 1) : cwp(rn, rd, 0, 0, 1, 8, 0);
            end
            "CBZ", "CBNZ": begin
                cw = cwp(rd, 0, 0, 0, 0, 4, 0); b = 1'b1;
                off = $signed(ins[23:5]);
                if ((m == "CBZ") == (st[0] == 1'b1)) npc = pc + 64'(off * 4);
            end
            "B": begin
                off = $signed(ins[25:0]);
                npc = pc + 64'(off * 4);
            end
            default: ;
        endcase
    endfunction

    task automatic apply_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        @(negedge clock);
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_cw", ControlWord, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        reset = 1'b0;
        mpc   = 64'h0;
    endtask

    // Starts on a negedge in FETCH; returns on the negedge inside EXEC.
    task automatic fetch(input logic [31:0] ins, input int unsigned delay);
        for (int unsigned i = 0; i < delay; i++) begin
            check("wait_req", imem_req, 1);
            check("wait_cw", ControlWord, 0);
            @(negedge clock);
        end
        check("fetch_addr", imem_addr, mpc);
        check("fetch_req", imem_req, 1);
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = $urandom;
    endtask

    task automatic exec_check(input logic [3:0] st, input logic [22:0] ecw, input logic [63:0] ek,
                              input logic eb, input logic [63:0] enext);
        status = st;
        #1;
        check("exec_cw", ControlWord, ecw);
        check("exec_const", Const, ek);
        check("exec_bsel", Bsel, eb);
        check("exec_req", imem_req, 0);
        @(negedge clock);
        check("next_pc", imem_addr, enext);
        mpc = enext;
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  st;
        logic [22:0] ecw;
        logic [63:0] ek, enext;
        logic        eb;

        r_ops = '{OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR};
        i_ops = '{OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI};

        vecs[0]  = '{32'h8B020020, 4'h0, cwp(1, 2, 0, 1, 0, 8, 0), 64'd0, 1'b0, 64'd4};
        vecs[1]  = '{enc_d(OPC_LDUR, -8, 4, 3), 4'h0, cwp(4, 0, 3, 1, 0, 8, 1), 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'd4};
        vecs[2]  = '{enc_d(OPC_STUR, 16, 4, 3), 4'h0, cwp(4, 3, 0, 0, 1, 8, 0), 64'd16, 1'b1, 64'd4};
        vecs[3]  = '{enc_r(OPC_SUB, 9, 8, 7), 4'h1, cwp(8, 9, 7, 1, 0, 9, 0), 64'd0, 1'b0, 64'd4};
        vecs[4]  = '{enc_r(OPC_AND, 12, 11, 10), 4'h0, cwp(11, 12, 10, 1, 0, 0, 0), 64'd0, 1'b0, 64'd4};
        vecs[5]  = '{enc_r(OPC_ORR, 15, 14, 13), 4'h0, cwp(14, 15, 13, 1, 0, 4, 0), 64'd0, 1'b0, 64'd4};
        vecs[6]  = '{enc_i(OPC_ADDI, 4095, 2, 1), 4'h0, cwp(2, 0, 1, 1, 0, 8, 0), 64'hFFF, 1'b1, 64'd4};
        vecs[7]  = '{enc_i(OPC_SUBI, 5, 4, 3), 4'h0, cwp(4, 0, 3, 1, 0, 9, 0), 64'd5, 1'b1, 64'd4};
        vecs[8]  = '{enc_i(OPC_ANDI, 2048, 6, 5), 4'h0, cwp(6, 0, 5, 1, 0, 0, 0), 64'd2048, 1'b1, 64'd4};
        vecs[9]  = '{enc_i(OPC_ORRI, 1, 8, 7), 4'h0, cwp(8, 0, 7, 1, 0, 4, 0), 64'd1, 1'b1, 64'd4};
        vecs[10] = '{enc_d(OPC_LDUR, 255, 31, 30), 4'h0, cwp(31, 0, 30, 1, 0, 8, 1), 64'd255, 1'b1, 64'd4};
        vecs[11] = '{enc_cb(OPC_CBNZ, 2, 5), 4'b1110, cwp(5, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'd8};
        vecs[12] = '{enc_cb(OPC_CBNZ, 2, 5), 4'b0001, cwp(5, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'd4};
        vecs[13] = '{enc_cb(OPC_CBZ, -1, 6), 4'b0000, cwp(6, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'd4};
        vecs[14] = '{enc_cb(OPC_CBZ, -1, 6), 4'b1111, cwp(6, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[15] = '{enc_b(3), 4'h0, 23'd0, 64'd0, 1'b0, 64'd12};

        apply_reset();

        for (int i = 0; i < 16; i++) begin
            fetch(vecs[i].ins, int'(unsigned'(i % 3)));
            exec_check(vecs[i].st, vecs[i].cw, vecs[i].k, vecs[i].b, mpc + vecs[i].delta);
        end

        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 4))
                0:       ins[31:21] = r_ops[$urandom_range(0, 3)];
                1:       ins[31:22] = i_ops[$urandom_range(0, 3)];
                2:       ins[31:21] = ($urandom_range(0, 1) == 1) ? OPC_LDUR : OPC_STUR;
                3:       ins[31:24] = ($urandom_range(0, 1) == 1) ? OPC_CBZ : OPC_CBNZ;
                default: ins[31:26] = OPC_B;
            endcase
            st = 4'($urandom);
            fetch(ins, $urandom_range(0, 2));
            ref_model(ins, st, mpc, ecw, ek, eb, enext);
            exec_check(st, ecw, ek, eb, enext);
        end

        // CBZ X5,+3 at PC 0x40, taken and not taken
        apply_reset();
        fetch(enc_b(16), 0);
        exec_check(4'h0, 23'd0, 64'd0, 1'b0, 64'h40);
        fetch(enc_cb(OPC_CBZ, 3, 5), 0);
        exec_check(4'b0001, cwp(5, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'h4C);
        apply_reset();
        fetch(enc_b(16), 0);
        exec_check(4'h0, 23'd0, 64'd0, 1'b0, 64'h40);
        fetch(enc_cb(OPC_CBZ, 3, 5), 0);
        exec_check(4'b0000, cwp(5, 0, 0, 0, 0, 4, 0), 64'd0, 1'b1, 64'h44);

        // B -1 from PC 0 wraps
        apply_reset();
        fetch(enc_b(-1), 1);
        exec_check(4'h0, 23'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);

        // Illegal opcode halts; ack in HALT is ignored
        fetch(32'hFFFF_FFFF, 0);
        #1;
        check("ill_cw", ControlWord, 0);
        check("ill_bsel", Bsel, 0);
        check("ill_req", imem_req, 0);
        @(negedge clock);
        check("ill_halted", halted, 1);
        check("ill_flag", illegal, 1);
        check("ill_pc", imem_addr, mpc);
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("halt_req", imem_req, 0);
            check("halt_stay", halted, 1);
            check("halt_cw", ControlWord, 0);
        end
        imem_ack = 1'b0;
        apply_reset();

        // Reset in the middle of a STUR execute drops MemWrite at once
        fetch(enc_d(OPC_STUR, 16, 4, 3), 0);
        #1;
        check("stur_mw", ControlWord[6], 1);
        reset = 1'b1;
        #1;
        check("rst_mw", ControlWord[6], 0);
        check("rst_mid_cw", ControlWord, 0);
        check("rst_mid_req", imem_req, 1);
        check("rst_mid_addr", imem_addr, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        mpc   = 64'h0;
        fetch(32'h8B020020, 0);
        exec_check(4'h0, cwp(1, 2, 0, 1, 0, 8, 0), 64'd0, 1'b0, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multicycle instruction sequencer that sits directly upstream of the LEGv8 datapath.
- Fetches 32-bit instructions over a req/ack handshake and holds them in an instruction register (IR).
- Decodes each instruction into the datapath's 23-bit control word, 64-bit constant and Bsel.
- Consumes the datapath status flags to resolve CBZ/CBNZ, and updates the 64-bit PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
PC_STEP, 4, byte increment for sequential fetch

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-high; clears all state
imem_req  output  1  fetch request; held high until ack
imem_ack  input  1  one-cycle pulse; imem_data valid in the same cycle
imem_addr  output  64  fetch address, always equal to the PC register
imem_data  input  32  instruction word
status  input  4  datapath flags {V,C,N,Z}, combinational from the ALU
ControlWord  output  23  {SA[4:0],SB[4:0],DA[4:0],RegWrite,MemWrite,FS[4:0],SD}
Const  output  64  immediate to the datapath B-mux
Bsel  output  1  1 = datapath B operand is Const
halted  output  1  high in HALT
illegal  output  1  sticky; set when an unrecognised opcode is executed

Behaviour:
- States: FETCH, EXEC, HALT. Encoding is 2 bits: FETCH=0, EXEC=1, HALT=2.
- Reset (asynchronous, active-high) sets: state=FETCH, PC=RESET_PC, IR=0, illegal=0. Reset mid-fetch or mid-exec aborts immediately, and no write strobe may be left asserted.
- FETCH:
  - imem_req=1.
  - On imem_ack: IR<=imem_data, then go to EXEC.
  - ControlWord=0, Const=0, Bsel=0, so RegWrite=MemWrite=0.
- EXEC (exactly 1 cycle; fields decoded from IR):
  - R-type ADD/SUB/AND/ORR:
    - SA=Rn, SB=Rm, DA=Rd, RegWrite=1, Bsel=0, SD=0.
    - FS = ADD 01000 / SUB 01001 / AND 00000 / ORR 00100.
  - I-type ADDI/SUBI/ANDI/ORRI:
    - SA=Rn, DA=Rd, RegWrite=1, Bsel=1, SD=0.
    - Const = zero-extended IR[21:10].
  - LDUR:
    - SA=Rn, DA=Rt, Bsel=1, FS=ADD, RegWrite=1, SD=1.
    - Const = sign-extended IR[20:12].
  - STUR:
    - SA=Rn, SB=Rt, Bsel=1, FS=ADD, MemWrite=1, RegWrite=0.
    - Const = sign-extended IR[20:12].
  - CBZ/CBNZ:
    - SA=Rt, Bsel=1, Const=0, FS=ORR, no writes.
    - Branch is taken when status[0]==1 (CBZ) or status[0]==0 (CBNZ).
  - B: no datapath activity; always taken.
  - Unused fields are driven to 0.
- PC update at the end of EXEC:
  - Taken: PC <= PC + (sign-extended offset << 2). CB offset is IR[23:5]; B offset is IR[25:0]. The base is the PC of the branch itself.
  - Otherwise: PC <= PC + PC_STEP.
  - Arithmetic is 64-bit modulo 2^64; wrap-around is legal.
  - After the update, go to FETCH.
- Opcode decode, evaluated widest-first: 11-bit R/D forms, then 10-bit I forms, then 8-bit CB forms, then 6-bit B.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000
  - LDUR 11111000010, STUR 11111000000
  - CBZ 10110100, CBNZ 10110101, B 000101
- Any other opcode: in EXEC, ControlWord=0; set illegal, go to HALT, PC unchanged.
- HALT: all outputs quiescent, imem_req=0, halted=1. The only exit is reset.
- Handshake rules:
  - imem_ack outside FETCH is ignored.
  - Back-to-back instructions cost a minimum of 2 cycles (ack in the FETCH cycle).
- Write strobes are asserted only in EXEC.

Optional Feature:
- Macro: LEGV8_CU_BCOND_EN.
- When defined:
  - Adds ADDS 10101011000 and SUBS 11101011000, decoded like ADD/SUB.
  - These also latch status into a 4-bit flag register NZCV at the end of EXEC. The flag register resets to 0.
  - Adds B.cond (opcode 01010100, cond=IR[3:0]: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL). The offset is IR[23:5], evaluated against the latched flags.
- When undefined: these opcodes are illegal and no flag register exists.

Decomposition:
- Package legv8_pkg holds:
  - opcode constants;
  - FS codes;
  - state enum;
  - the control-word field positions.
- One sub-module, legv8_imm_gen (combinational): produces Const and the branch offset from IR and an immediate-type select.

Test Plan:
- Reset with RESET_PC=0, then ack 0x8B020020 (ADD X0,X1,X2) -> EXEC ControlWord has SA=1, SB=2, DA=0, RegWrite=1, FS=01000, Bsel=0; imem_addr advances to 4.
- LDUR X3,[X4,#-8] -> Bsel=1, Const=64'hFFFF_FFFF_FFFF_FFF8, SD=1, RegWrite=1.
- STUR X3,[X4,#16] -> Const=16, MemWrite=1, RegWrite=0.
- CBZ X5,+3 at PC=0x40: with status=0001 the next imem_addr=0x4C; with status=0000 it is 0x44.
- Branching (B) with offset -1 at PC=0 -> PC=64'hFFFF_FFFF_FFFF_FFFC (wrap).
- Opcode 0xFFFFFFFF -> illegal=1, halted=1, imem_req stays 0. Asserting reset mid-EXEC of a STUR drops MemWrite immediately.
